// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types for the neuron fire stages
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        REFR
    } spk_state_t;

    typedef logic [3:0] count_t;

    localparam count_t COUNT_MAX = 4'd15;

endpackage

// File: rtl/refrac_timer.sv
// rtl/refrac_timer.sv - loadable down-counter timing a refractory window
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load, value   : start a window; busy stays high for value+1 cycles
//   busy          : registered, high for the whole window
//   done          : combinational, high on the last cycle of the window
module refrac_timer
    import neuron_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  count_t value,
    output logic   busy,
    output logic   done
);

    count_t rcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            busy <= 1'b0;
        end else if (load) begin
            rcnt <= value;
            busy <= 1'b1;
        end else if (busy) begin
            if (rcnt == '0) begin
                busy <= 1'b0;
            end else begin
                rcnt <= rcnt - 4'd1;
            end
        end
    end

    assign done = busy & (rcnt == '0);

endmodule

// File: rtl/count_spike_gen.sv
// rtl/count_spike_gen.sv - threshold-crossing spike generator with refractory period
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   count      : 4-bit counter value (membrane state), sampled every edge
//   up_dnb     : counter direction, 1 = up
//   spike      : one-cycle pulse on an accepted upward crossing of TH
//   wrap_up    : one-cycle pulse on count 15 -> 0
//   wrap_dn    : one-cycle pulse on count 0 -> 15
//   refrac     : high for REFRAC cycles after each spike
//   spike_cnt  : saturating tally of accepted spikes
module count_spike_gen
    import neuron_pkg::*;
#(
    parameter int TH     = 12,
    parameter int REFRAC = 3,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    count,
    input  logic          up_dnb,
    output logic          spike,
    output logic          wrap_up,
    output logic          wrap_dn,
    output logic          refrac,
    output logic [CW-1:0] spike_cnt
);

    if (TH < 1 || TH > 15) begin : g_bad_th
        $error("count_spike_gen: TH must be in 1..15");
    end

    if (REFRAC < 0 || REFRAC > 15) begin : g_bad_refrac
        $error("count_spike_gen: REFRAC must be in 0..15");
    end

    localparam count_t TH_Q      = count_t'(TH);
    localparam bit     NO_REFRAC = (REFRAC == 0);
    // The FIRE cycle itself is not part of the window, so the timer gets REFRAC-1.
    localparam count_t RF_LOAD   = NO_REFRAC ? 4'd0 : count_t'(REFRAC - 1);

    count_t     prev_q;
    logic       prev_vld;
    logic       xing;
    spk_state_t state;
    spk_state_t nxt;
    logic       tmr_load;
    logic       tmr_done;

    assign xing = prev_vld & up_dnb & (prev_q < TH_Q) & (count >= TH_Q);

    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        case (state)
            IDLE: begin
                if (xing) nxt = FIRE;
            end
            FIRE: begin
                if (NO_REFRAC) begin
                    nxt = xing ? FIRE : IDLE;
                end else begin
                    nxt      = REFR;
                    tmr_load = 1'b1;
                end
            end
            REFR: begin
                // Crossings seen here are dropped, not remembered.
                if (tmr_done) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev_vld  <= 1'b0;
            state     <= IDLE;
            spike     <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
            spike_cnt <= '0;
        end else begin
            prev_q   <= count;
            prev_vld <= 1'b1;
            state    <= nxt;
            spike    <= (nxt == FIRE);
            wrap_up  <= prev_vld & (prev_q == COUNT_MAX) & (count == '0);
            wrap_dn  <= prev_vld & (prev_q == '0) & (count == COUNT_MAX);
            if (nxt == FIRE && spike_cnt != {CW{1'b1}}) begin
                spike_cnt <= spike_cnt + CW'(1);
            end
        end
    end

    // The timer's busy flag is exactly the refractory window.
    refrac_timer u_refrac_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (RF_LOAD),
        .busy  (refrac),
        .done  (tmr_done)
    );

endmodule
